// File: rtl/brq_pkg.sv
// Shared types and helpers for the BRQ instruction-fetch front end.
//
// Contents:
//   fetch_req_state_e  request FSM states (IDLE, WAIT_GNT)
//   AddrStep           byte increment between sequential fetch words
//   align_word()       clears the two low address bits
package brq_pkg;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_GNT
    } fetch_req_state_e;

    localparam logic [31:0] AddrStep = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/brq_ifu_fetch_req_if.sv
// Instruction bus between the fetch request unit and memory.
//
// Signals:
//   instr_req     bus request (master -> slave)
//   instr_addr    word-aligned request address (master -> slave)
//   instr_gnt     request accepted (slave -> master)
//   instr_rvalid  response valid, in request order (slave -> master)
//   instr_rdata   response data (slave -> master)
//   instr_err     response error (slave -> master)
interface brq_ifu_fetch_req_if;

    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata,
        input  instr_err
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata,
        output instr_err
    );

endinterface

// File: rtl/brq_ifu_fetch_req.sv
// Instruction fetch request generator.
//
// Issues sequential word fetches on the instruction bus, redirects on branch,
// keeps up to NUM_REQS requests in flight and forwards in-order responses to
// the fetch FIFO, dropping responses that belong to a pre-branch stream.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   req_i              fetch enable
//   branch_i, addr_i   single-cycle redirect and its target
//   busy_o             request pending or responses outstanding
//   bus                instruction bus (master side)
//   fifo_busy_i        FIFO upper-entry occupancy
//   fifo_clear_o       FIFO clear (on branch), fifo_addr_o its address
//   fifo_valid_o       FIFO push, with fifo_rdata_o / fifo_err_o
module brq_ifu_fetch_req
    import brq_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic                       branch_i,
    input  logic [31:0]                addr_i,
    output logic                       busy_o,
    brq_ifu_fetch_req_if.master        bus,
    input  logic [NUM_REQS-1:0]        fifo_busy_i,
    output logic                       fifo_clear_o,
    output logic                       fifo_valid_o,
    output logic [31:0]                fifo_addr_o,
    output logic [31:0]                fifo_rdata_o,
    output logic                       fifo_err_o
);

    localparam int unsigned CntW = $clog2(NUM_REQS + 1);

    fetch_req_state_e    state_q;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [31:0]         req_addr_q;
    logic                pending_q, pending_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    // Slot 0 is the oldest outstanding request; slots [cnt_q-1:0] are live.
    logic [NUM_REQS-1:0] discard_q, discard_d;

    logic                new_req;
    logic                granted;
    logic                popped;
    logic                push_discard;
    logic [31:0]         branch_addr;
    int unsigned         busy_cnt;

    always_comb begin
        busy_cnt = 0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            busy_cnt += 32'(fifo_busy_i[i]);
        end
        // A branch may issue even with the FIFO full, since the FIFO is cleared.
        new_req = req_i
                & (((32'(cnt_q) + busy_cnt) < NUM_REQS) | branch_i)
                & (32'(cnt_q) < NUM_REQS);
    end

    always_comb begin
        branch_addr = align_word(addr_i);
        if (state_q == WAIT_GNT) begin
            bus.instr_req  = 1'b1;
            bus.instr_addr = req_addr_q;
        end else begin
            bus.instr_req  = new_req;
            bus.instr_addr = branch_i ? branch_addr : fetch_addr_q;
        end
    end

    assign granted = bus.instr_req & bus.instr_gnt;
    assign popped  = bus.instr_rvalid & (cnt_q != '0);

    assign busy_o       = bus.instr_req | (cnt_q != '0);
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_rdata_o = bus.instr_rdata;
    assign fifo_err_o   = bus.instr_err;
    assign fifo_valid_o = popped & ~discard_q[0] & ~branch_i;

    // A request stuck in WAIT_GNT across a branch fetches the old stream.
    assign push_discard = pending_q | (branch_i & (state_q == WAIT_GNT));

    always_comb begin
        discard_d = discard_q;
        cnt_d     = cnt_q;
        if (popped) begin
            discard_d = discard_q >> 1;
            cnt_d     = cnt_q - CntW'(1);
        end
        if (branch_i) begin
            for (int i = 0; i < int'(NUM_REQS); i++) begin
                if (i < int'(cnt_d)) begin
                    discard_d[i] = 1'b1;
                end
            end
        end
        if (granted) begin
            for (int i = 0; i < int'(NUM_REQS); i++) begin
                if (i == int'(cnt_d)) begin
                    discard_d[i] = push_discard;
                end
            end
            cnt_d = cnt_d + CntW'(1);
        end
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        // While a branch is pending, fetch_addr_q already holds the target.
        if (granted && !(state_q == WAIT_GNT && pending_q)) begin
            fetch_addr_d = bus.instr_addr + AddrStep;
        end
        if (branch_i) begin
            fetch_addr_d = (granted && state_q == IDLE) ? branch_addr + AddrStep : branch_addr;
        end

        pending_d = pending_q;
        if (state_q == WAIT_GNT) begin
            if (granted) begin
                pending_d = 1'b0;
            end else if (branch_i) begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            req_addr_q   <= '0;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            discard_q    <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            discard_q    <= discard_d;
            case (state_q)
                IDLE: begin
                    if (new_req && !bus.instr_gnt) begin
                        state_q    <= WAIT_GNT;
                        req_addr_q <= bus.instr_addr;
                    end
                end
                WAIT_GNT: begin
                    if (bus.instr_gnt) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brq_ifu_fetch_req.sv
// Directed self-checking bench for brq_ifu_fetch_req (NUM_REQS = 2).
module tb_brq_ifu_fetch_req;

    logic        clk;
    logic        rst;
    logic        req;
    logic        branch;
    logic [31:0] addr;
    logic        busy;
    logic [1:0]  fifo_busy;
    logic        fifo_clear;
    logic        fifo_valid;
    logic [31:0] fifo_addr;
    logic [31:0] fifo_rdata;
    logic        fifo_err;

    int n_checks = 0;
    int n_errors = 0;

    brq_ifu_fetch_req_if bus ();

    brq_ifu_fetch_req #(
        .NUM_REQS (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .branch_i     (branch),
        .addr_i       (addr),
        .busy_o       (busy),
        .bus          (bus),
        .fifo_busy_i  (fifo_busy),
        .fifo_clear_o (fifo_clear),
        .fifo_valid_o (fifo_valid),
        .fifo_addr_o  (fifo_addr),
        .fifo_rdata_o (fifo_rdata),
        .fifo_err_o   (fifo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                 = 1'b1;
        req                 = 1'b0;
        branch              = 1'b0;
        addr                = '0;
        fifo_busy           = '0;
        bus.instr_gnt       = 1'b0;
        bus.instr_rvalid    = 1'b0;
        bus.instr_rdata     = '0;
        bus.instr_err       = 1'b0;

        #2;
        chk("rst_req", bus.instr_req, 0);
        chk("rst_addr", bus.instr_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fvalid", fifo_valid, 0);
        chk("rst_fclear", fifo_clear, 0);
        step();
        rst = 1'b0;

        // Branch to 0x100 with grant every cycle: 0x100, 0x104, then stall.
        req = 1'b1; branch = 1'b1; addr = 32'h100; bus.instr_gnt = 1'b1;
        #1;
        chk("b100_req", bus.instr_req, 1);
        chk("b100_addr", bus.instr_addr, 32'h100);
        chk("b100_clear", fifo_clear, 1);
        chk("b100_faddr", fifo_addr, 32'h100);
        step();
        branch = 1'b0;
        #1;
        chk("seq_addr", bus.instr_addr, 32'h104);
        chk("seq_req", bus.instr_req, 1);
        step();
        #1;
        chk("stall_req", bus.instr_req, 0);
        chk("stall_busy", busy, 1);
        step();
        #1;
        chk("stall_req2", bus.instr_req, 0);
        bus.instr_rvalid = 1'b1; bus.instr_rdata = 32'hAAAA0001;
        #1;
        chk("rsp1_valid", fifo_valid, 1);
        chk("rsp1_data", fifo_rdata, 32'hAAAA0001);
        chk("rsp1_req", bus.instr_req, 0);
        step();

        // One outstanding, grant and rvalid together: count stays at one.
        bus.instr_rdata = 32'hAAAA0002; bus.instr_err = 1'b1;
        #1;
        chk("gr_req", bus.instr_req, 1);
        chk("gr_addr", bus.instr_addr, 32'h108);
        chk("gr_valid", fifo_valid, 1);
        chk("gr_err", fifo_err, 1);
        chk("gr_data", fifo_rdata, 32'hAAAA0002);
        step();
        bus.instr_rvalid = 1'b0; bus.instr_err = 1'b0;
        #1;
        chk("cnt1_req", bus.instr_req, 1);
        chk("cnt1_addr", bus.instr_addr, 32'h10C);
        step();
        #1;
        chk("cnt2_req", bus.instr_req, 0);

        // Drain with req low, then an rvalid with nothing outstanding.
        req = 1'b0; bus.instr_gnt = 1'b0; bus.instr_rvalid = 1'b1;
        #1;
        chk("drain1", fifo_valid, 1);
        step();
        #1;
        chk("drain2", fifo_valid, 1);
        step();
        #1;
        chk("spur_valid", fifo_valid, 0);
        chk("spur_busy", busy, 0);
        step();
        bus.instr_rvalid = 1'b0;
        #1;
        chk("no_underflow", busy, 0);

        // Grant withheld at 0x200, branch to 0x300 while waiting.
        req = 1'b1; branch = 1'b1; addr = 32'h200;
        #1;
        chk("w200_addr", bus.instr_addr, 32'h200);
        step();
        branch = 1'b0;
        #1;
        chk("wait1_addr", bus.instr_addr, 32'h200);
        chk("wait1_req", bus.instr_req, 1);
        step();
        branch = 1'b1; addr = 32'h300;
        #1;
        chk("wait2_addr", bus.instr_addr, 32'h200);
        chk("wait2_clear", fifo_clear, 1);
        step();
        branch = 1'b0;
        #1;
        chk("wait3_addr", bus.instr_addr, 32'h200);
        step();
        bus.instr_gnt = 1'b1;
        #1;
        chk("gnt200_addr", bus.instr_addr, 32'h200);
        step();
        #1;
        chk("tgt300_req", bus.instr_req, 1);
        chk("tgt300_addr", bus.instr_addr, 32'h300);
        step();
        req = 1'b0; bus.instr_gnt = 1'b0; bus.instr_rvalid = 1'b1;
        #1;
        chk("stale200_valid", fifo_valid, 0);
        step();
        #1;
        chk("rsp300_valid", fifo_valid, 1);
        step();
        bus.instr_rvalid = 1'b0;

        // Two outstanding (0x304, 0x308), branch to 0x402 drops both.
        req = 1'b1; bus.instr_gnt = 1'b1;
        #1;
        chk("o304_addr", bus.instr_addr, 32'h304);
        step();
        step();
        branch = 1'b1; addr = 32'h402;
        #1;
        chk("b402_req", bus.instr_req, 0);
        chk("b402_clear", fifo_clear, 1);
        chk("b402_faddr", fifo_addr, 32'h402);
        step();
        branch = 1'b0; req = 1'b0; bus.instr_rvalid = 1'b1;
        #1;
        chk("b402_clear_off", fifo_clear, 0);
        chk("drop1", fifo_valid, 0);
        step();
        #1;
        chk("drop2", fifo_valid, 0);
        step();
        bus.instr_rvalid = 1'b0; req = 1'b1;
        #1;
        chk("r400_req", bus.instr_req, 1);
        chk("r400_addr", bus.instr_addr, 32'h400);
        step();
        req = 1'b0; bus.instr_gnt = 1'b0; bus.instr_rvalid = 1'b1;
        #1;
        chk("r400_valid", fifo_valid, 1);
        step();
        bus.instr_rvalid = 1'b0;

        // FIFO full: no sequential request, but a branch still issues.
        fifo_busy = 2'b11; req = 1'b1;
        #1;
        chk("full_req", bus.instr_req, 0);
        step();
        branch = 1'b1; addr = 32'h500; bus.instr_gnt = 1'b1;
        #1;
        chk("full_br_req", bus.instr_req, 1);
        chk("full_br_addr", bus.instr_addr, 32'h500);
        step();
        branch = 1'b0;
        #1;
        chk("full_after", bus.instr_req, 0);
        fifo_busy = 2'b00; req = 1'b0; bus.instr_gnt = 1'b0; bus.instr_rvalid = 1'b1;
        #1;
        chk("r500_valid", fifo_valid, 1);
        step();
        bus.instr_rvalid = 1'b0;

        // Address wrap at the top of memory.
        req = 1'b1; branch = 1'b1; addr = 32'hFFFF_FFFC; bus.instr_gnt = 1'b1;
        #1;
        chk("top_addr", bus.instr_addr, 32'hFFFF_FFFC);
        step();
        branch = 1'b0;
        #1;
        chk("wrap_req", bus.instr_req, 1);
        chk("wrap_addr", bus.instr_addr, 32'h0);
        step();
        req = 1'b0; bus.instr_gnt = 1'b0; bus.instr_rvalid = 1'b1;
        step();
        step();
        bus.instr_rvalid = 1'b0;

        // Reset while waiting for a grant abandons the request.
        req = 1'b1;
        #1;
        chk("pre_rst_addr", bus.instr_addr, 32'h4);
        step();
        #1;
        chk("pre_rst_wait", bus.instr_req, 1);
        rst = 1'b1; req = 1'b0;
        #1;
        chk("mid_rst_req", bus.instr_req, 0);
        chk("mid_rst_addr", bus.instr_addr, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_req", bus.instr_req, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
